// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath blocks.
//   FFT_N_POINTS / FFT_DATA_W : default frame length and sample width.
//   bit_reverse()             : reverses the low 'width' bits of an index (width <= FFT_MAX_ADDR_W).
package fft_pkg;

  localparam int unsigned FFT_N_POINTS   = 32;
  localparam int unsigned FFT_DATA_W     = 11;
  localparam int unsigned FFT_MAX_ADDR_W = 10;  // supports frames up to 1024 points
  localparam int unsigned FFT_IDX_W      = 4;   // enough bits to index FFT_MAX_ADDR_W

  // Bits at and above 'width' in the result are zero.
  function automatic logic [FFT_MAX_ADDR_W-1:0] bit_reverse(
    input logic [FFT_MAX_ADDR_W-1:0] value,
    input int unsigned               width
  );
    logic [FFT_MAX_ADDR_W-1:0] result;
    result = '0;
    for (int unsigned i = 0; i < FFT_MAX_ADDR_W; i++) begin
      if (i < width) begin
        result[FFT_IDX_W'(i)] = value[FFT_IDX_W'(width - 1 - i)];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame bank of the bit-reverse buffer: sample storage, a full flag and the
// output-order mode latched for the frame it holds.
//   clk_i, rst_i     : clock, asynchronous active-high reset (flags only, not storage)
//   we_i             : write wr_data_i at wr_addr_i
//   mode_we_i/mode_i : latch the frame's output-order mode
//   set_full_i       : frame complete; clr_full_i : frame fully read out
//   rd_addr_i        : asynchronous read address -> rd_data_o
//   full_o, mode_o   : current flag and latched mode
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W = FFT_DATA_W,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              mode_we_i,
  input  logic              mode_i,
  input  logic              set_full_i,
  input  logic              clr_full_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              mode_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic              full_q, full_d;
  logic              mode_q, mode_d;

  // Storage is deliberately not reset; it is only read once full_q is set.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // A bank is never written while full, so set and clear cannot coincide.
  always_comb begin
    full_d = full_q;
    mode_d = mode_q;
    if (set_full_i) begin
      full_d = 1'b1;
    end else if (clr_full_i) begin
      full_d = 1'b0;
    end
    if (mode_we_i) begin
      mode_d = mode_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      full_q <= full_d;
      mode_q <= mode_d;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];
  assign full_o    = full_q;
  assign mode_o    = mode_q;

endmodule

// File: rtl/fft_bitrev_buffer.sv
// Ping-pong frame buffer that reorders FFT samples into bit-reversed or natural order.
//   clk, rst     : clock, asynchronous active-high reset
//   valid_i      : data_i carries a natural-order sample; taken when ready_o is high
//   bitrev_i     : output-order mode, sampled on each frame's first sample
//   ready_o      : the current write bank has room
//   valid_o      : data_o carries an output beat; last_o marks the frame's final beat
//   out_ready_i  : downstream takes data_o this cycle
module fft_bitrev_buffer
  import fft_pkg::*;
#(
  parameter int unsigned N_POINTS = FFT_N_POINTS,
  parameter int unsigned DATA_W   = FFT_DATA_W,
  parameter int unsigned ADDR_W   = $clog2(N_POINTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              bitrev_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  input  logic              out_ready_i
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(N_POINTS - 1);

  logic              wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [1:0]        full, mode, bank_we, mode_we, set_full, clr_full;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  logic              accept, wr_last, rd_done;
  logic              load, sel_bank;
  logic [ADDR_W-1:0] sel_beat, rev_beat;

  // Write side
  assign ready_o = ~full[wr_bank_q];
  assign accept  = valid_i & ready_o;
  assign wr_last = (wr_idx_q == LastIdx);

  assign bank_we  = {accept & wr_bank_q, accept & ~wr_bank_q};
  assign mode_we  = bank_we & {2{wr_idx_q == '0}};
  assign set_full = bank_we & {2{wr_last}};

  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    if (accept) begin
      if (wr_last) begin
        wr_idx_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end
  end

  // Read side: banks fill and drain in the same alternating order, so when idle
  // rd_bank_q already names the next bank to read.
  assign rd_done  = valid_q & out_ready_i & last_q;
  assign clr_full = {rd_done & rd_bank_q, rd_done & ~rd_bank_q};

  always_comb begin
    valid_d   = valid_q;
    last_d    = last_q;
    rd_idx_d  = rd_idx_q;
    rd_bank_d = rd_bank_q;
    load      = 1'b0;
    sel_bank  = rd_bank_q;
    sel_beat  = rd_idx_q + 1'b1;
    if (!valid_q) begin
      if (full[rd_bank_q]) begin
        load     = 1'b1;
        sel_beat = '0;
      end
    end else if (out_ready_i) begin
      if (last_q) begin
        rd_bank_d = ~rd_bank_q;
        valid_d   = 1'b0;
        last_d    = 1'b0;
        // Chain straight into the other bank so back-to-back frames have no bubble.
        if (full[~rd_bank_q]) begin
          load     = 1'b1;
          sel_bank = ~rd_bank_q;
          sel_beat = '0;
        end
      end else begin
        load = 1'b1;
      end
    end
    if (load) begin
      valid_d  = 1'b1;
      rd_idx_d = sel_beat;
      last_d   = (sel_beat == LastIdx);
    end
  end

  // Each bank translates the beat index using its own latched mode.
  always_comb begin
    rev_beat   = ADDR_W'(bit_reverse(FFT_MAX_ADDR_W'(sel_beat), ADDR_W));
    rd_addr[0] = mode[0] ? rev_beat : sel_beat;
    rd_addr[1] = mode[1] ? rev_beat : sel_beat;
  end

  always_comb begin
    data_d = load ? rd_data[sel_bank] : data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_idx_q  <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_bank_q <= rd_bank_d;
      rd_idx_q  <= rd_idx_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      data_q    <= data_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_bank (
      .clk_i     (clk),
      .rst_i     (rst),
      .we_i      (bank_we[b]),
      .wr_addr_i (wr_idx_q),
      .wr_data_i (data_i),
      .mode_we_i (mode_we[b]),
      .mode_i    (bitrev_i),
      .set_full_i(set_full[b]),
      .clr_full_i(clr_full[b]),
      .rd_addr_i (rd_addr[b]),
      .rd_data_o (rd_data[b]),
      .full_o    (full[b]),
      .mode_o    (mode[b])
    );
  end

  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
module tb_fft_bitrev_buffer;

  localparam int N  = 32;
  localparam int DW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_i = 1'b0;
  logic          bitrev_i = 1'b0;
  logic          out_ready_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          ready_o, valid_o, last_o;
  logic [DW-1:0] data_o;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [DW-1:0] beat_d_q[$];
  logic          beat_l_q[$];
  int            beat_c_q[$];
  int            acc_c_q[$];
  int            stall_c_q[$];

  fft_bitrev_buffer #(
    .N_POINTS(N),
    .DATA_W  (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .bitrev_i   (bitrev_i),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .last_o     (last_o),
    .out_ready_i(out_ready_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record handshakes mid-cycle, where inputs and registered outputs are settled.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o && out_ready_i) begin
        beat_d_q.push_back(data_o);
        beat_l_q.push_back(last_o);
        beat_c_q.push_back(cyc);
      end
      if (valid_i && ready_o) acc_c_q.push_back(cyc);
      else if (valid_i) stall_c_q.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  function automatic int br5(input int m);
    logic [4:0] v;
    v = 5'(m);
    return int'({v[0], v[1], v[2], v[3], v[4]});
  endfunction

  task automatic clear_mon();
    beat_d_q.delete();
    beat_l_q.delete();
    beat_c_q.delete();
    acc_c_q.delete();
    stall_c_q.delete();
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d, input logic br, input logic ordy);
    valid_i     = v;
    data_i      = d;
    bitrev_i    = br;
    out_ready_i = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, ordy);
  endtask

  task automatic send_frame(input int base, input logic br, input logic ordy);
    int k;
    int guard;
    k = 0;
    guard = 0;
    while (k < N && guard < 400) begin
      valid_i     = 1'b1;
      data_i      = DW'(base + k);
      bitrev_i    = br;
      out_ready_i = ordy;
      if (ready_o) k++;
      @(posedge clk);
      #1;
      guard++;
    end
    valid_i = 1'b0;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, '0, 1'b0, 1'b1);
    clear_mon();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_total++; if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready_o); else n_pass++;
    n_total++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o); else n_pass++;
    n_total++; if (last_o !== 1'b0) $display("FAIL reset_last: got %b want 0", last_o); else n_pass++;
    n_total++; if (data_o !== '0) $display("FAIL reset_data: got %0d want 0", data_o); else n_pass++;
    release_rst();
  endtask

  task automatic test_frame_order(input logic mode);
    int exp;
    clear_mon();
    send_frame(0, mode, 1'b1);
    idle(40, 1'b1);
    n_total++;
    if (beat_d_q.size() != N) $display("FAIL order_count mode=%b: got %0d beats want %0d", mode, beat_d_q.size(), N);
    else n_pass++;
    for (int m = 0; m < N && m < beat_d_q.size(); m++) begin
      exp = mode ? br5(m) : m;
      n_total++;
      if (beat_d_q[m] !== DW'(exp) || beat_l_q[m] !== (m == N - 1))
        $display("FAIL order_beat mode=%b m=%0d: got data %0d last %b want data %0d last %b",
                 mode, m, beat_d_q[m], beat_l_q[m], exp, (m == N - 1));
      else n_pass++;
    end
    n_total++;
    if (beat_d_q.size() < 2 || beat_d_q[1] !== (mode ? 11'd16 : 11'd1))
      $display("FAIL order_beat1 mode=%b: got %0d want %0d", mode,
               (beat_d_q.size() < 2) ? -1 : int'(beat_d_q[1]), mode ? 16 : 1);
    else n_pass++;
    n_total++;
    if (beat_c_q.size() == 0 || acc_c_q.size() != N || beat_c_q[0] != acc_c_q[N - 1] + 2)
      $display("FAIL order_latency mode=%b: got first beat cycle %0d want %0d", mode,
               (beat_c_q.size() == 0) ? -1 : beat_c_q[0],
               (acc_c_q.size() != N) ? -1 : acc_c_q[N - 1] + 2);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int exp;
    clear_mon();
    send_frame(0, 1'b1, 1'b1);
    send_frame(100, 1'b1, 1'b1);
    idle(80, 1'b1);
    n_total++; if (stall_c_q.size() != 0) $display("FAIL b2b_ready: got %0d stalled cycles want 0", stall_c_q.size()); else n_pass++;
    n_total++;
    if (acc_c_q.size() != 2 * N || acc_c_q[2 * N - 1] - acc_c_q[0] != 2 * N - 1)
      $display("FAIL b2b_accept: got %0d accepts want %0d contiguous", acc_c_q.size(), 2 * N);
    else n_pass++;
    n_total++;
    if (beat_c_q.size() != 2 * N || beat_c_q[2 * N - 1] - beat_c_q[0] != 2 * N - 1)
      $display("FAIL b2b_gapless: got %0d beats want %0d contiguous", beat_c_q.size(), 2 * N);
    else n_pass++;
    for (int m = 0; m < 2 * N && m < beat_d_q.size(); m++) begin
      exp = ((m >= N) ? 100 : 0) + br5(m % N);
      n_total++;
      if (beat_d_q[m] !== DW'(exp) || beat_l_q[m] !== (m % N == N - 1))
        $display("FAIL b2b_beat m=%0d: got data %0d last %b want data %0d last %b",
                 m, beat_d_q[m], beat_l_q[m], exp, (m % N == N - 1));
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int   base [3];
    logic mode [3];
    int   k;
    int   guard;
    int   f;
    int   exp;
    base = '{200, 300, 400};
    mode = '{1'b1, 1'b0, 1'b1};
    k = 0;
    clear_mon();
    for (guard = 0; guard < 80; guard++) begin
      valid_i = 1'b1; data_i = DW'(base[k / N] + k % N); bitrev_i = mode[k / N]; out_ready_i = 1'b0;
      if (ready_o) k++;
      @(posedge clk);
      #1;
    end
    n_total++; if (k != 2 * N) $display("FAIL bp_stored: got %0d accepted want %0d", k, 2 * N); else n_pass++;
    n_total++; if (ready_o !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", ready_o); else n_pass++;
    n_total++; if (valid_o !== 1'b1) $display("FAIL bp_valid_hold: got %b want 1", valid_o); else n_pass++;
    n_total++; if (data_o !== 11'd200) $display("FAIL bp_data_hold: got %0d want 200", data_o); else n_pass++;
    n_total++;
    if (stall_c_q.size() == 0 || acc_c_q.size() != 2 * N || stall_c_q[0] != acc_c_q[2 * N - 1] + 1)
      $display("FAIL bp_ready_fall: got first stall cycle %0d want %0d",
               (stall_c_q.size() == 0) ? -1 : stall_c_q[0],
               (acc_c_q.size() != 2 * N) ? -1 : acc_c_q[2 * N - 1] + 1);
    else n_pass++;
    guard = 0;
    while (k < 3 * N && guard < 300) begin
      valid_i = 1'b1; data_i = DW'(base[k / N] + k % N); bitrev_i = mode[k / N]; out_ready_i = 1'b1;
      if (ready_o) k++;
      @(posedge clk);
      #1;
      guard++;
    end
    valid_i = 1'b0;
    idle(120, 1'b1);
    n_total++; if (k != 3 * N) $display("FAIL bp_frame3: got %0d accepted want %0d", k, 3 * N); else n_pass++;
    n_total++;
    if (beat_d_q.size() != 3 * N) $display("FAIL bp_count: got %0d beats want %0d", beat_d_q.size(), 3 * N);
    else n_pass++;
    n_total++;
    if (acc_c_q.size() != 3 * N || beat_c_q.size() < N || acc_c_q[2 * N] <= beat_c_q[N - 1])
      $display("FAIL bp_frame3_order: frame 3 accepted at cycle %0d, required after frame 1 drain",
               (acc_c_q.size() != 3 * N) ? -1 : acc_c_q[2 * N]);
    else n_pass++;
    for (int m = 0; m < 3 * N && m < beat_d_q.size(); m++) begin
      f   = m / N;
      exp = base[f] + (mode[f] ? br5(m % N) : m % N);
      n_total++;
      if (beat_d_q[m] !== DW'(exp) || beat_l_q[m] !== (m % N == N - 1))
        $display("FAIL bp_beat m=%0d: got data %0d last %b want data %0d last %b",
                 m, beat_d_q[m], beat_l_q[m], exp, (m % N == N - 1));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    for (int k = 0; k < 10; k++) step(1'b1, DW'(700 + k), 1'b1, 1'b1);
    valid_i = 1'b0;
    rst = 1'b1;
    #2;
    n_total++; if (ready_o !== 1'b1) $display("FAIL rstw_ready: got %b want 1", ready_o); else n_pass++;
    n_total++; if (valid_o !== 1'b0) $display("FAIL rstw_valid: got %b want 0", valid_o); else n_pass++;
    release_rst();
    send_frame(800, 1'b1, 1'b1);
    idle(6, 1'b1);
    n_total++; if (valid_o !== 1'b1) $display("FAIL rstr_pre_valid: got %b want 1", valid_o); else n_pass++;
    n_total++; if (beat_d_q.size() != 5) $display("FAIL rstr_pre_count: got %0d beats want 5", beat_d_q.size()); else n_pass++;
    for (int m = 0; m < beat_d_q.size(); m++) begin
      n_total++;
      if (beat_d_q[m] !== DW'(800 + br5(m)))
        $display("FAIL rstr_pre_beat m=%0d: got %0d want %0d", m, beat_d_q[m], 800 + br5(m));
      else n_pass++;
    end
    valid_i = 1'b0;
    rst = 1'b1;
    #2;
    n_total++; if (valid_o !== 1'b0) $display("FAIL rstr_valid: got %b want 0", valid_o); else n_pass++;
    n_total++; if (data_o !== '0) $display("FAIL rstr_data: got %0d want 0", data_o); else n_pass++;
    n_total++; if (last_o !== 1'b0) $display("FAIL rstr_last: got %b want 0", last_o); else n_pass++;
    n_total++; if (ready_o !== 1'b1) $display("FAIL rstr_ready: got %b want 1", ready_o); else n_pass++;
    release_rst();
    send_frame(900, 1'b0, 1'b1);
    idle(45, 1'b1);
    n_total++;
    if (beat_d_q.size() != N) $display("FAIL rst_clean_count: got %0d beats want %0d", beat_d_q.size(), N);
    else n_pass++;
    for (int m = 0; m < N && m < beat_d_q.size(); m++) begin
      n_total++;
      if (beat_d_q[m] !== DW'(900 + m) || beat_l_q[m] !== (m == N - 1))
        $display("FAIL rst_clean_beat m=%0d: got data %0d last %b want data %0d last %b",
                 m, beat_d_q[m], beat_l_q[m], 900 + m, (m == N - 1));
      else n_pass++;
    end
  endtask

  task automatic test_toggle();
    int   k;
    int   guard;
    int   base;
    int   exp;
    logic m0;
    for (int f = 0; f < 2; f++) begin
      k     = 0;
      guard = 0;
      m0    = (f == 0);
      base  = 500 + 100 * f;
      clear_mon();
      while (k < N && guard < 200) begin
        valid_i     = (guard % 2 == 0);
        data_i      = DW'(base + k);
        bitrev_i    = (k < 10) ? m0 : ~m0;
        out_ready_i = 1'b1;
        if (valid_i && ready_o) k++;
        @(posedge clk);
        #1;
        guard++;
      end
      valid_i = 1'b0;
      idle(45, 1'b1);
      n_total++;
      if (beat_d_q.size() != N) $display("FAIL tog_count f=%0d: got %0d beats want %0d", f, beat_d_q.size(), N);
      else n_pass++;
      n_total++;
      if (beat_c_q.size() == 0 || acc_c_q.size() != N || beat_c_q[0] != acc_c_q[N - 1] + 2)
        $display("FAIL tog_latency f=%0d: got first beat cycle %0d want %0d", f,
                 (beat_c_q.size() == 0) ? -1 : beat_c_q[0],
                 (acc_c_q.size() != N) ? -1 : acc_c_q[N - 1] + 2);
      else n_pass++;
      for (int m = 0; m < N && m < beat_d_q.size(); m++) begin
        exp = base + (m0 ? br5(m) : m);
        n_total++;
        if (beat_d_q[m] !== DW'(exp) || beat_l_q[m] !== (m == N - 1))
          $display("FAIL tog_beat f=%0d m=%0d: got data %0d last %b want data %0d last %b",
                   f, m, beat_d_q[m], beat_l_q[m], exp, (m == N - 1));
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_order(1'b1);
    test_frame_order(1'b0);
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_toggle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_buffer.md
FFT_BITREV_BUFFER -- requirements
Module: fft_bitrev_buffer

Interface
REQ-001 SHALL have parameter N_POINTS, default 32: frame length; power of two, 8..1024.
REQ-002 SHALL have parameter DATA_W, default 11: sample width in bits.
REQ-003 SHALL have parameter ADDR_W, default $clog2(N_POINTS): sample index width; derived, not overridden.
REQ-004 SHALL have port clk  input  1: single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst  input  1: reset; asynchronous and active-high.
REQ-006 SHALL have port valid_i  input  1: data_i holds a sample this cycle.
REQ-007 SHALL have port data_i  input  DATA_W: input sample, natural order.
REQ-008 SHALL have port bitrev_i  input  1: frame mode; 1 = bit-reversed output, 0 = natural order.
REQ-009 SHALL have port ready_o  output  1: buffer can accept a sample this cycle.
REQ-010 SHALL have port valid_o  output  1: data_o holds a sample.
REQ-011 SHALL have port data_o  output  DATA_W: output sample.
REQ-012 SHALL have port last_o  output  1: data_o is the final sample of its frame.
REQ-013 SHALL have port out_ready_i  input  1: downstream accepts data_o this cycle.

Function
REQ-014 SHALL hold two banks of N_POINTS x DATA_W (ping-pong); one bank is written while the other is read.
REQ-015 SHALL accept a sample only when valid_i && ready_o; idle cycles inside a frame are allowed and do not advance the write index.
REQ-016 SHALL sample bitrev_i on a frame's first accepted sample and hold it for that bank until the bank has been read out.
REQ-017 SHALL write accepted sample k (k = 0..N_POINTS-1) to address k of the write bank; on k = N_POINTS-1 it marks the bank full, resets the write index to 0 and swaps to the other bank.
REQ-018 SHALL drive ready_o = 0 while the current write bank is full; otherwise ready_o = 1.
REQ-019 SHALL start reading a full bank on the cycle after it becomes full, provided no other bank is being read; valid_o rises on the edge after the edge that wrote sample N_POINTS-1.
REQ-020 SHALL present on output beat m the sample at address bitrev(m) over ADDR_W bits when the bank's mode is 1, or at address m when it is 0.
REQ-021 SHALL hold data_o, valid_o and last_o stable while valid_o && !out_ready_i, and advance only on valid_o && out_ready_i.
REQ-022 SHALL assert last_o only on beat m = N_POINTS-1; when that beat is accepted it clears the bank's full flag in the same cycle.
REQ-023 SHALL, when the other bank is full at that point, start its beat 0 on the next cycle with no bubble; back-to-back frames with out_ready_i = 1 stream with no gap.
REQ-024 SHALL, when a bank's full flag clears in the same cycle that the opposite bank becomes full, update both flags with no lost or repeated frame.
REQ-025 SHALL, when the write bank is freed in the same cycle that a sample is offered, not accept that sample; ready_o rises on the following cycle.

Reset
REQ-026 SHALL, while rst = 1, force ready_o = 1, valid_o = 0, last_o = 0, data_o = 0, write/read indices = 0, both full flags = 0, write bank = 0, read bank = 0.
REQ-027 SHALL, on reset mid-frame or mid-readout, discard all partial and stored frames; the first sample accepted after rst falls is sample 0 of a new frame.
REQ-028 SHALL leave bank storage contents uninitialised by reset; no output may expose them.

Structure
REQ-029 SHALL take from shared package fft_pkg: the bit-reverse function (width-generic) and the default DATA_W / N_POINTS constants used across the FFT blocks.
REQ-030 SHALL instantiate one sub-module fft_frame_bank twice; each instance holds storage, full flag and latched mode. Control and output mux stay in fft_bitrev_buffer.

Verification
REQ-031 SHALL cover: N_POINTS=32, DATA_W=11, bitrev_i=1, samples 0..31 on consecutive cycles, out_ready_i=1 -> outputs 0,16,8,24,4,20,... ,31; last_o only with 31; valid_o rises 1 cycle after sample 31 is written.
REQ-032 SHALL cover: same stimulus with bitrev_i=0 -> outputs 0..31 in order.
REQ-033 SHALL cover: two frames back-to-back (0..31, then 100..131) with out_ready_i=1 -> ready_o stays 1 throughout; 64 output beats with no gap; last_o on beats 31 and 63.
REQ-034 SHALL cover: out_ready_i=0 while 3 frames are offered -> ready_o falls after sample 31 of frame 2; data_o holds frame 1 beat 0; on out_ready_i=1, frames 1 and 2 drain intact, then frame 3 is accepted.
REQ-035 SHALL cover: rst pulsed after 10 samples of frame 1 and again mid-readout of a frame -> outputs go to reset values; the next 32 samples form a clean frame whose output is correct.
REQ-036 SHALL cover: valid_i toggling 1/0 every cycle during a frame, then bitrev_i changed mid-frame -> frame is complete after 32 accepted samples; output order follows the mode sampled on that frame's first sample.
